// File: rtl/dilate_pkg.sv
// Shared definitions for the row-serial dilation sequencer.
//   IMG_DIM  : image side length (32)
//   IMG_BITS : flattened image width (1024)
//   ROW_W    : width of a row index
//   state_t  : sequencer states
//   pix_idx  : flat bit index of pixel (r, c)
package dilate_pkg;

    localparam int unsigned IMG_DIM  = 32;
    localparam int unsigned IMG_BITS = IMG_DIM * IMG_DIM;
    localparam int unsigned ROW_W    = $clog2(IMG_DIM);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    function automatic int unsigned pix_idx(input int unsigned r, input int unsigned c);
        return IMG_DIM * r + c;
    endfunction

endpackage

// File: rtl/dilate_row.sv
// Combinational cross-dilation kernel for one 32-pixel row.
//   up  : row above (zero when absent)
//   cur : row being produced
//   dn  : row below (zero when absent)
//   out : out[c] = cur[c] | cur[c-1] | cur[c+1] | up[c] | dn[c]
module dilate_row
    import dilate_pkg::*;
(
    input  logic [IMG_DIM-1:0] up,
    input  logic [IMG_DIM-1:0] cur,
    input  logic [IMG_DIM-1:0] dn,
    output logic [IMG_DIM-1:0] out
);

    // Shifts insert zeros, so column 0 sees no left neighbour and
    // column 31 no right neighbour: rows never wrap into each other.
    always_comb begin
        out = cur | (cur << 1) | (cur >> 1) | up | dn;
    end

endmodule

// File: rtl/dilate_pass_ctrl.sv
// Row-serial sequencer applying N passes of 4-neighbour binary dilation
// to a 32x32 image using one shared row kernel and ping-pong buffers.
//   clk, rst   : clock, synchronous active-high reset
//   start      : job request, accepted only when idle
//   passes     : pass count, sampled with start
//   in_image   : source image, bit 32*r+c = pixel(r,c), sampled with start
//   busy       : job in progress (includes the done cycle)
//   done       : one-cycle pulse; results valid from this cycle
//   out_image  : result, bit-reversed
//   show_image : result, natural order
module dilate_pass_ctrl
    import dilate_pkg::*;
#(
    parameter int unsigned PASS_W = 3,
    parameter int unsigned DIM    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PASS_W-1:0]   passes,
    input  logic [IMG_BITS-1:0] in_image,
    output logic                busy,
    output logic                done,
    output logic [IMG_BITS-1:0] out_image,
    output logic [IMG_BITS-1:0] show_image
);

    if (DIM != IMG_DIM) begin : g_dim_check
        $error("dilate_pass_ctrl: DIM must be 32");
    end

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [PASS_W-1:0]   passes_q, passes_d;
    logic                sel_q, sel_d;
    logic [IMG_BITS-1:0] buf0_q, buf0_d;
    logic [IMG_BITS-1:0] buf1_q, buf1_d;
    logic [IMG_BITS-1:0] out_q, out_d;
    logic [IMG_BITS-1:0] show_q, show_d;

    logic [IMG_BITS-1:0] src_img;
    logic [IMG_BITS-1:0] dst_img;
    logic [IMG_BITS-1:0] final_img;
    logic [IMG_BITS-1:0] final_rev;
    logic [IMG_DIM-1:0]  up_row;
    logic [IMG_DIM-1:0]  cur_row;
    logic [IMG_DIM-1:0]  dn_row;
    logic [IMG_DIM-1:0]  new_row;

    // sel_q=0: buf0 is the source, buf1 the destination.
    always_comb begin
        src_img = sel_q ? buf1_q : buf0_q;
        dst_img = sel_q ? buf0_q : buf1_q;
        cur_row = src_img[pix_idx(32'(row_q), 0) +: IMG_DIM];
        up_row  = '0;
        dn_row  = '0;
        if (row_q != '0) begin
            up_row = src_img[pix_idx(32'(row_q) - 1, 0) +: IMG_DIM];
        end
        if (row_q != ROW_W'(IMG_DIM - 1)) begin
            dn_row = src_img[pix_idx(32'(row_q) + 1, 0) +: IMG_DIM];
        end
    end

    dilate_row u_row (
        .up  (up_row),
        .cur (cur_row),
        .dn  (dn_row),
        .out (new_row)
    );

    // Outputs are loaded on the edge entering FIN so they are already valid
    // while done is high. In RUN that edge also writes the last row, so the
    // result is assembled from the destination buffer plus the kernel output.
    always_comb begin
        final_img = in_image;
        if (state_q == RUN) begin
            final_img = {new_row, dst_img[IMG_BITS-IMG_DIM-1:0]};
        end
        for (int unsigned i = 0; i < IMG_BITS; i++) begin
            final_rev[IMG_BITS-1-i] = final_img[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        pass_d   = pass_q;
        passes_d = passes_q;
        sel_d    = sel_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        out_d    = out_q;
        show_d   = show_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    buf0_d   = in_image;
                    sel_d    = 1'b0;
                    passes_d = passes;
                    pass_d   = PASS_W'(1);
                    row_d    = '0;
                    if (passes == '0) begin
                        state_d = FIN;
                        out_d   = final_rev;
                        show_d  = final_img;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (sel_q) begin
                    buf0_d[pix_idx(32'(row_q), 0) +: IMG_DIM] = new_row;
                end else begin
                    buf1_d[pix_idx(32'(row_q), 0) +: IMG_DIM] = new_row;
                end
                row_d = row_q + 1'b1;
                if (row_q == ROW_W'(IMG_DIM - 1)) begin
                    row_d = '0;
                    if (pass_q < passes_q) begin
                        sel_d  = ~sel_q;
                        pass_d = pass_q + 1'b1;
                    end else begin
                        state_d = FIN;
                        out_d   = final_rev;
                        show_d  = final_img;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            pass_q   <= '0;
            passes_q <= '0;
            sel_q    <= 1'b0;
            buf0_q   <= '0;
            buf1_q   <= '0;
            out_q    <= '0;
            show_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            pass_q   <= pass_d;
            passes_q <= passes_d;
            sel_q    <= sel_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            out_q    <= out_d;
            show_q   <= show_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign out_image  = out_q;
    assign show_image = show_q;

endmodule

// File: tb/tb_dilate_pass_ctrl.sv
// Self-checking bench for dilate_pass_ctrl: directed corner/edge cases,
// handshake timing, start-while-busy, mid-job reset and random jobs,
// all compared against a pixel-level reference model.
module tb_dilate_pass_ctrl;

    localparam int N    = 32;
    localparam int BITS = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      passes;
    logic [BITS-1:0] in_image;
    logic            busy;
    logic            done;
    logic [BITS-1:0] out_image;
    logic [BITS-1:0] show_image;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dilate_pass_ctrl #(.PASS_W(3), .DIM(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .passes     (passes),
        .in_image   (in_image),
        .busy       (busy),
        .done       (done),
        .out_image  (out_image),
        .show_image (show_image)
    );

    // Reference: a pixel is set if it or any in-range cross neighbour was set.
    function automatic logic [BITS-1:0] ref_dilate(input logic [BITS-1:0] img, input int n);
        logic [BITS-1:0] cur;
        logic [BITS-1:0] nxt;
        int dr [5] = '{0, 0, 0, -1, 1};
        int dc [5] = '{0, -1, 1, 0, 0};
        cur = img;
        for (int k = 0; k < n; k++) begin
            nxt = '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    for (int j = 0; j < 5; j++) begin
                        int rr;
                        int cc;
                        rr = r + dr[j];
                        cc = c + dc[j];
                        if (rr >= 0 && rr < N && cc >= 0 && cc < N && cur[rr*N+cc])
                            nxt[r*N+c] = 1'b1;
                    end
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    function automatic logic [BITS-1:0] reverse(input logic [BITS-1:0] img);
        logic [BITS-1:0] r;
        for (int i = 0; i < BITS; i++) r[BITS-1-i] = img[i];
        return r;
    endfunction

    function automatic logic [BITS-1:0] mk5(input int a, input int b, input int c, input int d, input int e);
        logic [BITS-1:0] v;
        int l [5];
        v = '0;
        l = '{a, b, c, d, e};
        for (int i = 0; i < 5; i++) if (l[i] >= 0) v[l[i]] = 1'b1;
        return v;
    endfunction

    function automatic logic [BITS-1:0] rand_img(input int density);
        logic [BITS-1:0] v;
        for (int i = 0; i < N; i++) begin
            logic [31:0] w;
            w = $urandom;
            for (int k = 1; k < density; k++) w = w & $urandom;
            v[i*N +: N] = w;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_img(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        int first;
        first = -1;
        for (int i = BITS - 1; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: first differing bit %0d observed=%b expected=%b (popcount observed %0d expected %0d)",
                   tag, first, obs[first], exp[first], $countones(obs), $countones(exp));
        end
    endtask

    // Starts a job in the current cycle and returns in the done cycle.
    // intr_at > 0 pulses start (with a different image) at that cycle of the job.
    task automatic run_job(input logic [BITS-1:0] img, input int p, input string tag, input int intr_at);
        logic [BITS-1:0] prev_show;
        int lat;
        int busy_bad;
        int moved;
        prev_show = show_image;
        in_image  = img;
        passes    = 3'(p);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        lat       = -1;
        busy_bad  = 0;
        moved     = 0;
        for (int k = 1; k <= 300; k++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (show_image !== prev_show) moved++;
            start    = (k == intr_at);
            in_image = ~img;
            passes   = 3'($urandom);
            tick();
            start    = 1'b0;
        end
        chk({tag, " latency"}, 64'(lat), 64'(32 * p + 1));
        chk({tag, " busy"}, 64'(busy_bad), 64'd0);
        chk({tag, " held"}, 64'(moved), 64'd0);
        chk_img({tag, " show"}, show_image, ref_dilate(img, p));
        chk_img({tag, " out"}, out_image, reverse(ref_dilate(img, p)));
    endtask

    task automatic after_done(input string tag);
        tick();
        chk({tag, " done drop"}, 64'(done), 64'd0);
        chk({tag, " busy drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [BITS-1:0] img;
        int dcount;
        rst      = 1'b1;
        start    = 1'b0;
        passes   = '0;
        in_image = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk_img("reset show", show_image, '0);
        chk_img("reset out", out_image, '0);

        // Single pixel (5,7)
        img = '0;
        img[167] = 1'b1;
        run_job(img, 1, "pix167", 0);
        chk_img("pix167 const show", show_image, mk5(135, 166, 167, 168, 199));
        chk_img("pix167 const out", out_image, mk5(888, 855, 856, 857, 824));
        after_done("pix167");

        // Corners and row-end edge
        img = '0;
        img[0] = 1'b1;
        run_job(img, 1, "corner0", 0);
        chk_img("corner0 const", show_image, mk5(0, 1, 32, -1, -1));
        after_done("corner0");
        img = '0;
        img[1023] = 1'b1;
        run_job(img, 1, "corner1023", 0);
        chk_img("corner1023 const", show_image, mk5(1023, 1022, 991, -1, -1));
        after_done("corner1023");
        img = '0;
        img[31] = 1'b1;
        run_job(img, 1, "edge31", 0);
        chk_img("edge31 const", show_image, mk5(31, 30, 63, -1, -1));
        after_done("edge31");

        // Radius-2 diamond
        img = '0;
        img[528] = 1'b1;
        run_job(img, 2, "diamond", 0);
        chk("diamond popcount", 64'($countones(show_image)), 64'd13);
        chk("diamond bits", 64'({show_image[464], show_image[526], show_image[530],
                                 show_image[592], show_image[463]}), 64'b11110);
        after_done("diamond");

        // passes=0 passthrough, all-zero, all-ones
        img = rand_img(1);
        run_job(img, 0, "pass0", 0);
        chk_img("pass0 identity", show_image, img);
        after_done("pass0");
        run_job('0, 7, "zeros7", 0);
        chk_img("zeros7 const", show_image, '0);
        after_done("zeros7");
        run_job('1, 1, "ones1", 0);
        chk_img("ones1 const", show_image, '1);
        after_done("ones1");

        // start during a running job is ignored; start at done+1 is accepted
        img = rand_img(4);
        run_job(img, 1, "ignore", 10);
        tick();
        chk("ignore no 2nd done", 64'(done), 64'd0);
        img = rand_img(3);
        run_job(img, 3, "back2back", 0);
        after_done("back2back");

        // Mid-job reset
        img = rand_img(2);
        in_image = img;
        passes   = 3'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk_img("rst show", show_image, '0);
        chk_img("rst out", out_image, '0);
        dcount = 0;
        for (int k = 0; k < 120; k++) begin
            if (done === 1'b1) dcount++;
            tick();
        end
        chk("rst no done", 64'(dcount), 64'd0);
        img = rand_img(4);
        run_job(img, 2, "post_rst", 0);
        after_done("post_rst");

        // Random jobs
        for (int t = 0; t < 5; t++) begin
            img = rand_img(int'($urandom_range(2, 4)));
            run_job(img, int'($urandom_range(0, 7)), $sformatf("rand%0d", t), 0);
            after_done($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
